// File: rtl/mac_mdc_par_if.sv
// Stream bundle for mac_mdc_par: operand streams a/b, accumulator-init stream c, result stream d.
interface mac_mdc_par_if #(
  parameter int unsigned DATA_W = 32
);
  logic              a_TVALID;
  logic              a_TREADY;
  logic [DATA_W-1:0] a_TDATA;
  logic              b_TVALID;
  logic              b_TREADY;
  logic [DATA_W-1:0] b_TDATA;
  logic              c_TVALID;
  logic              c_TREADY;
  logic [DATA_W-1:0] c_TDATA;
  logic              d_TVALID;
  logic              d_TREADY;
  logic [DATA_W-1:0] d_TDATA;
  logic              d_TLAST;

  // Fabric side: produces a/b/c, consumes d.
  modport master (
    output a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    input  a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA, d_TLAST
  );

  // Engine side.
  modport slave (
    input  a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA, d_TREADY,
    output a_TREADY, b_TREADY, c_TREADY, d_TVALID, d_TDATA, d_TLAST
  );
endinterface

// File: rtl/mac_mdc_par.sv
// Parametrised multiply-accumulate stream engine (scalar product or element-wise multiply).
// Optional output saturation enabled by defining MAC_MDC_PAR_SAT_EN.
module mac_mdc_par #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned CNT_MAX = 1024,
  localparam int unsigned SHIFT_W = $clog2(DATA_W),
  localparam int unsigned LEN_W   = $clog2(CNT_MAX + 1),
  localparam int unsigned PROD_W  = 2 * DATA_W,
  localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(CNT_MAX)
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  mac_mdc_par_if.slave       axis,
  input  logic               simple_mul,
  input  logic               signed_mode,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               sat
);

`ifdef MAC_MDC_PAR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACC, S_OUT, S_STREAM} state_t;

  state_t              state_q, state_nx;
  logic                cfg_signed;
  logic [SHIFT_W-1:0]  cfg_shift;
  logic [LEN_W-1:0]    cfg_len;
  logic [LEN_W-1:0]    in_cnt, acc_cnt, acc_cnt_p1;
  logic [PROD_W-1:0]   r_mult;
  logic                r_mult_valid;
  logic [ACC_W-1:0]    r_acc;

  logic                ab_ready_c, c_ready_c, d_valid_c, d_last_c;
  logic                ab_fire, c_fire, d_fire, acc_fire, last_acc, last_d;
  logic [PROD_W-1:0]   a_ext, b_ext, prod_c;
  logic [ACC_W-1:0]    c_ext, mult_ext, d_src, d_srl, d_sra, d_wide;
  logic signed [ACC_W-1:0] d_src_s;
  logic [ACC_W-DATA_W:0]   top_s;
  logic                fits, clamp_c;
  logic [DATA_W-1:0]   clamp_val, d_data_c;

  assign acc_cnt_p1 = acc_cnt + LEN_W'(1);

  // Operand extension follows the latched mode; low PROD_W bits of the
  // product of sign/zero-extended operands are exact in both modes.
  assign a_ext    = {{(PROD_W-DATA_W){cfg_signed & axis.a_TDATA[DATA_W-1]}}, axis.a_TDATA};
  assign b_ext    = {{(PROD_W-DATA_W){cfg_signed & axis.b_TDATA[DATA_W-1]}}, axis.b_TDATA};
  assign prod_c   = a_ext * b_ext;
  assign c_ext    = {{(ACC_W-DATA_W){cfg_signed & axis.c_TDATA[DATA_W-1]}}, axis.c_TDATA};
  assign mult_ext = {{(ACC_W-PROD_W){cfg_signed & r_mult[PROD_W-1]}}, r_mult};

  // Result path: post-shift (arithmetic when signed), then narrow.
  assign d_src   = (state_q == S_OUT) ? r_acc : mult_ext;
  assign d_src_s = d_src;
  assign d_sra   = d_src_s >>> cfg_shift;
  assign d_srl   = d_src >> cfg_shift;
  assign d_wide  = cfg_signed ? d_sra : d_srl;

  assign top_s     = d_wide[ACC_W-1:DATA_W-1];
  assign fits      = cfg_signed ? ((&top_s) | ~(|top_s)) : ~(|top_s[ACC_W-DATA_W:1]);
  assign clamp_c   = SAT_EN & ~fits;
  assign clamp_val = !cfg_signed      ? {DATA_W{1'b1}} :
                     d_wide[ACC_W-1]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                        {1'b0, {(DATA_W-1){1'b1}}};
  assign d_data_c  = clamp_c ? clamp_val : d_wide[DATA_W-1:0];

  // Output decode from current state.
  always_comb begin
    ab_ready_c = 1'b0;
    c_ready_c  = 1'b0;
    d_valid_c  = 1'b0;
    d_last_c   = 1'b0;
    case (state_q)
      S_LOAD:   c_ready_c = 1'b1;
      // A held product is always drained in ACC, so only the count gates the join.
      S_ACC:    ab_ready_c = axis.a_TVALID & axis.b_TVALID & (in_cnt < cfg_len);
      S_OUT: begin
        d_valid_c = 1'b1;
        d_last_c  = 1'b1;
      end
      S_STREAM: begin
        ab_ready_c = axis.a_TVALID & axis.b_TVALID & (~r_mult_valid | axis.d_TREADY)
                   & (in_cnt < cfg_len);
        d_valid_c  = r_mult_valid;
        d_last_c   = (acc_cnt_p1 == cfg_len);
      end
      default: ;
    endcase
  end

  assign ab_fire  = ab_ready_c;
  assign c_fire   = c_ready_c & axis.c_TVALID;
  assign d_fire   = d_valid_c & axis.d_TREADY;
  assign acc_fire = (state_q == S_ACC) & r_mult_valid;
  assign last_acc = acc_fire & (acc_cnt_p1 == cfg_len);
  assign last_d   = d_fire & d_last_c;

  assign axis.a_TREADY = ab_ready_c;
  assign axis.b_TREADY = ab_ready_c;
  assign axis.c_TREADY = c_ready_c;
  assign axis.d_TVALID = d_valid_c;
  assign axis.d_TLAST  = d_last_c;
  assign axis.d_TDATA  = d_data_c;

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:   state_nx = simple_mul ? S_STREAM : S_LOAD;
      S_LOAD:   if (c_fire) state_nx = (cfg_len != '0) ? S_ACC : S_OUT;
      S_ACC:    if (last_acc) state_nx = S_OUT;
      S_OUT:    if (d_fire) state_nx = S_IDLE;
      S_STREAM: if (last_d) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_nx;
  end

  // Datapath, counters, configuration and status.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cfg_signed   <= 1'b0;
      cfg_shift    <= '0;
      cfg_len      <= '0;
      in_cnt       <= '0;
      acc_cnt      <= '0;
      r_mult       <= '0;
      r_mult_valid <= 1'b0;
      r_acc        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= last_d;
      if (state_q == S_IDLE) begin
        cfg_signed   <= signed_mode;
        cfg_shift    <= shift;
        cfg_len      <= (simple_mul && len == '0) ? LEN_W'(1) : len;
        in_cnt       <= '0;
        acc_cnt      <= '0;
        r_mult_valid <= 1'b0;
        sat          <= 1'b0;
      end else begin
        sat <= sat | (d_valid_c & clamp_c);
      end
      if (c_fire) begin
        r_acc   <= c_ext << cfg_shift;
        in_cnt  <= '0;
        acc_cnt <= '0;
      end
      if (ab_fire) begin
        r_mult <= prod_c;
        in_cnt <= in_cnt + LEN_W'(1);
      end
      if (acc_fire) begin
        r_acc   <= r_acc + mult_ext;
        acc_cnt <= acc_cnt_p1;
      end
      if (d_fire && state_q == S_STREAM) acc_cnt <= acc_cnt_p1;
      if (ab_fire)                      r_mult_valid <= 1'b1;
      else if (acc_fire || d_fire)      r_mult_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_mdc_par.sv
// Directed bench for mac_mdc_par (DATA_W=32, CNT_MAX=1024).
module tb_mac_mdc_par;
  localparam int unsigned DW = 32;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        simple_mul, signed_mode;
  logic [4:0]  shift;
  logic [10:0] len;
  logic        busy, done, sat;
  int          total = 0;
  int          bad   = 0;

  mac_mdc_par_if #(.DATA_W(DW)) axis ();

  mac_mdc_par #(.DATA_W(DW), .CNT_MAX(1024)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .axis        (axis),
    .simple_mul  (simple_mul),
    .signed_mode (signed_mode),
    .shift       (shift),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .sat         (sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic start_job(input logic sm, input logic sg, input logic [4:0] sh, input logic [10:0] ln);
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0; axis.c_TVALID = 1'b0; axis.d_TREADY = 1'b0;
    simple_mul = sm; signed_mode = sg; shift = sh; len = ln;
    ap_rst_n = 1'b0;
    cyc(); cyc();
    ap_rst_n = 1'b1;
  endtask

  task automatic push_c(input logic [31:0] v, output bit ok);
    axis.c_TDATA = v; axis.c_TVALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (axis.c_TREADY) begin ok = 1'b1; cyc(); break; end
      cyc();
    end
    axis.c_TVALID = 1'b0;
  endtask

  task automatic push_ab(input logic [31:0] av, input logic [31:0] bv, output bit ok);
    axis.a_TDATA = av; axis.b_TDATA = bv; axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (axis.a_TREADY) begin ok = 1'b1; cyc(); break; end
      cyc();
    end
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0;
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (axis.d_TVALID) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    axis.a_TDATA = 32'd1; axis.b_TDATA = 32'd2; axis.c_TDATA = 32'd3;
    axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1; axis.c_TVALID = 1'b1; axis.d_TREADY = 1'b1;
    simple_mul = 1'b0; signed_mode = 1'b0; shift = '0; len = 11'd1;
    ap_rst_n = 1'b0;
    cyc(); #1;
    v = {axis.a_TREADY, axis.b_TREADY, axis.c_TREADY, axis.d_TVALID, axis.d_TLAST, busy, done, sat};
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_outputs got=%b exp=00000000", v); end
    cyc(); #1;
    total++;
    if (axis.c_TREADY !== 1'b0) begin bad++; $display("FAIL reset_hold_c_ready got=%b exp=0", axis.c_TREADY); end
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0; axis.c_TVALID = 1'b0; axis.d_TREADY = 1'b0;
  endtask

  task automatic test_scalar();
    logic [31:0] av[3] = '{32'd1, 32'd2, 32'd3};
    logic [31:0] bv[3] = '{32'd4, 32'd5, 32'd6};
    bit ok;
    int acked;
    start_job(1'b0, 1'b1, 5'd0, 11'd3);
    push_c(32'd10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL scalar_c_handshake got=timeout exp=ack"); end
    len = 11'd1;
    for (int i = 0; i < 3; i++) begin
      push_ab(av[i], bv[i], ok);
      total++;
      if (!ok) begin bad++; $display("FAIL scalar_pair%0d got=timeout exp=ack", i); end
    end
    axis.a_TDATA = 32'd7; axis.b_TDATA = 32'd7; axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1;
    acked = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (axis.a_TREADY) acked++;
      if (axis.d_TVALID) break;
      cyc();
    end
    total++;
    if (acked !== 0) begin bad++; $display("FAIL scalar_extra_pair got=%0d acks exp=0", acked); end
    total++;
    if (axis.d_TVALID !== 1'b1 || axis.d_TDATA !== 32'd42 || axis.d_TLAST !== 1'b1) begin
      bad++; $display("FAIL scalar_result got=v%b d=%0d last=%b exp=v1 d=42 last=1",
                      axis.d_TVALID, axis.d_TDATA, axis.d_TLAST);
    end
    axis.d_TREADY = 1'b1;
    #1;
    total++;
    if (axis.a_TREADY !== 1'b0) begin bad++; $display("FAIL scalar_extra_pair_out got=%b exp=0", axis.a_TREADY); end
    cyc();
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL scalar_done got=done%b busy%b exp=done1 busy0", done, busy); end
    cyc();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL scalar_done_pulse got=%b exp=0", done); end
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0; axis.d_TREADY = 1'b0;
  endtask

  task automatic test_simple();
    bit ok;
    start_job(1'b1, 1'b1, 5'd1, 11'd2);
    axis.d_TREADY = 1'b1;
    axis.a_TDATA = 32'hFFFF_FFFD; axis.b_TDATA = 32'd7; axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (axis.a_TREADY) begin ok = 1'b1; break; end
      cyc();
    end
    total++;
    if (!ok || axis.d_TVALID !== 1'b0) begin bad++; $display("FAIL simple_first_accept got=ok%b dv%b exp=ok1 dv0", ok, axis.d_TVALID); end
    cyc();
    axis.a_TDATA = 32'd8; axis.b_TDATA = 32'd2;
    #1;
    total++;
    if (axis.d_TVALID !== 1'b1 || axis.d_TDATA !== 32'hFFFF_FFF5 || axis.d_TLAST !== 1'b0 || axis.a_TREADY !== 1'b1) begin
      bad++; $display("FAIL simple_out1 got=v%b d=%h last=%b rdy=%b exp=v1 d=fffffff5 last=0 rdy=1",
                      axis.d_TVALID, axis.d_TDATA, axis.d_TLAST, axis.a_TREADY);
    end
    cyc();
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0;
    #1;
    total++;
    if (axis.d_TVALID !== 1'b1 || axis.d_TDATA !== 32'd8 || axis.d_TLAST !== 1'b1) begin
      bad++; $display("FAIL simple_out2 got=v%b d=%h last=%b exp=v1 d=00000008 last=1",
                      axis.d_TVALID, axis.d_TDATA, axis.d_TLAST);
    end
    cyc();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL simple_done got=%b exp=1", done); end
    axis.d_TREADY = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_d;
    start_job(1'b1, 1'b0, 5'd0, 11'd4);
    push_ab(32'd1, 32'd10, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL bp_first_accept got=timeout exp=ack"); end
    axis.a_TDATA = 32'd2; axis.b_TDATA = 32'd10; axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (axis.a_TREADY !== 1'b0 || axis.d_TVALID !== 1'b1 || axis.d_TDATA !== 32'd10) begin
        bad++; $display("FAIL bp_stall%0d got=rdy%b v%b d=%0d exp=rdy0 v1 d=10",
                        k, axis.a_TREADY, axis.d_TVALID, axis.d_TDATA);
      end
      cyc();
    end
    axis.d_TREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_d = 32'(10 * (k + 1));
      total++;
      if (axis.d_TVALID !== 1'b1 || axis.d_TDATA !== exp_d || axis.d_TLAST !== (k == 3)) begin
        bad++; $display("FAIL bp_out%0d got=v%b d=%0d last=%b exp=v1 d=%0d last=%0d",
                        k, axis.d_TVALID, axis.d_TDATA, axis.d_TLAST, exp_d, (k == 3));
      end
      if (k < 3) begin
        total++;
        if (axis.a_TREADY !== 1'b1) begin bad++; $display("FAIL bp_rate%0d got=%b exp=1", k, axis.a_TREADY); end
      end
      cyc();
      if (k < 2) axis.a_TDATA = 32'(k + 3);
      else begin axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0; end
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
    axis.d_TREADY = 1'b0;
  endtask

  task automatic test_len0();
    bit ok;
    start_job(1'b0, 1'b0, 5'd4, 11'd0);
    axis.a_TDATA = 32'd9; axis.b_TDATA = 32'd9;
    push_c(32'h55, ok);
    axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1;
    wait_dv(ok);
    total++;
    if (!ok || axis.d_TDATA !== 32'h55 || axis.d_TLAST !== 1'b1) begin
      bad++; $display("FAIL len0_result got=ok%b d=%h last=%b exp=ok1 d=00000055 last=1", ok, axis.d_TDATA, axis.d_TLAST);
    end
    total++;
    if (axis.a_TREADY !== 1'b0 || axis.c_TREADY !== 1'b0) begin
      bad++; $display("FAIL len0_readies got=a%b c%b exp=a0 c0", axis.a_TREADY, axis.c_TREADY);
    end
    axis.d_TREADY = 1'b1;
    cyc();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL len0_done got=%b exp=1", done); end
    axis.a_TVALID = 1'b0; axis.b_TVALID = 1'b0; axis.d_TREADY = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] exp_d;
    logic        exp_sat;
`ifdef MAC_MDC_PAR_SAT_EN
    exp_d = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
    exp_d = 32'h0000_0001; exp_sat = 1'b0;
`endif
    start_job(1'b0, 1'b1, 5'd0, 11'd1);
    push_c(32'd0, ok);
    push_ab(32'h7FFF_FFFF, 32'h7FFF_FFFF, ok);
    wait_dv(ok);
    total++;
    if (!ok || axis.d_TDATA !== exp_d) begin bad++; $display("FAIL ovf_data got=%h exp=%h", axis.d_TDATA, exp_d); end
    axis.d_TREADY = 1'b1;
    cyc();
    total++;
    if (sat !== exp_sat || done !== 1'b1) begin bad++; $display("FAIL ovf_sat got=sat%b done%b exp=sat%b done1", sat, done, exp_sat); end
    axis.d_TREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [4:0] v;
    start_job(1'b0, 1'b1, 5'd0, 11'd4);
    push_c(32'd0, ok);
    push_ab(32'd2, 32'd3, ok);
    push_ab(32'd4, 32'd5, ok);
    axis.a_TDATA = 32'd6; axis.b_TDATA = 32'd7; axis.a_TVALID = 1'b1; axis.b_TVALID = 1'b1;
    axis.c_TVALID = 1'b1; axis.d_TREADY = 1'b1;
    #1;
    ap_rst_n = 1'b0;
    #1;
    v = {axis.a_TREADY, axis.c_TREADY, axis.d_TVALID, busy, done};
    total++;
    if (v !== 5'b0) begin bad++; $display("FAIL midrst_outputs got=%b exp=00000", v); end
    cyc();
    start_job(1'b0, 1'b0, 5'd0, 11'd2);
    push_c(32'd5, ok);
    push_ab(32'd3, 32'd2, ok);
    push_ab(32'd4, 32'd5, ok);
    wait_dv(ok);
    total++;
    if (!ok || axis.d_TDATA !== 32'd31 || axis.d_TLAST !== 1'b1) begin
      bad++; $display("FAIL midrst_next_job got=ok%b d=%0d last=%b exp=ok1 d=31 last=1", ok, axis.d_TDATA, axis.d_TLAST);
    end
    axis.d_TREADY = 1'b1;
    cyc();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b exp=1", done); end
    axis.d_TREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scalar();
    test_simple();
    test_backpressure();
    test_len0();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
